// File: rtl/ysyx_23060203_mem_arb.sv
// Read-only AXI arbiter: two requesters (IFU, LSU) share a single downstream
// read port. Only one transaction is in flight at a time, and every
// transaction passes through IDLE once, which costs a 1-cycle bubble.
// Optional feature: define YSYX_23060203_ARB_RR_EN for round-robin between
// simultaneous requests. Without it, LSU always wins a tie.
module ysyx_23060203_mem_arb #(
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  // IFU read address / data
  input  logic              ifu_arvalid,
  output logic              ifu_arready,
  input  logic [ADDR_W-1:0] ifu_araddr,
  input  logic [7:0]        ifu_arlen,
  input  logic [2:0]        ifu_arsize,
  output logic              ifu_rvalid,
  input  logic              ifu_rready,
  output logic [31:0]       ifu_rdata,
  output logic [1:0]        ifu_rresp,
  output logic              ifu_rlast,
  // LSU read address / data
  input  logic              lsu_arvalid,
  output logic              lsu_arready,
  input  logic [ADDR_W-1:0] lsu_araddr,
  input  logic [7:0]        lsu_arlen,
  input  logic [2:0]        lsu_arsize,
  output logic              lsu_rvalid,
  input  logic              lsu_rready,
  output logic [31:0]       lsu_rdata,
  output logic [1:0]        lsu_rresp,
  output logic              lsu_rlast,
  // downstream memory
  output logic              mem_arvalid,
  input  logic              mem_arready,
  output logic [ADDR_W-1:0] mem_araddr,
  output logic [7:0]        mem_arlen,
  output logic [2:0]        mem_arsize,
  input  logic              mem_rvalid,
  output logic              mem_rready,
  input  logic [31:0]       mem_rdata,
  input  logic [1:0]        mem_rresp,
  input  logic              mem_rlast
);

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_owner_q, last_owner_d;
  logic   grant_lsu;

  logic              own_arvalid;
  logic              own_rready;
  logic [ADDR_W-1:0] own_araddr;
  logic [7:0]        own_arlen;
  logic [2:0]        own_arsize;
  logic              in_addr;
  logic              in_data;
  logic              sel_ifu;
  logic              sel_lsu;

  // Route the current owner's request signals onto a common set of wires
  always_comb begin
    if (owner_q == OWN_LSU) begin
      own_arvalid = lsu_arvalid;
      own_rready  = lsu_rready;
      own_araddr  = lsu_araddr;
      own_arlen   = lsu_arlen;
      own_arsize  = lsu_arsize;
    end else begin
      own_arvalid = ifu_arvalid;
      own_rready  = ifu_rready;
      own_araddr  = ifu_araddr;
      own_arlen   = ifu_arlen;
      own_arsize  = ifu_arsize;
    end
  end

`ifdef YSYX_23060203_ARB_RR_EN
  // On a tie, the requester that did not own the bus last time wins.
  assign grant_lsu = lsu_arvalid & (~ifu_arvalid | (last_owner_q == OWN_IFU));
`else
  // Fixed priority: LSU wins any tie; last_owner is tracked but not consulted.
  assign grant_lsu = lsu_arvalid;
`endif

  // Next-state logic: grant in IDLE, wait for the AR handshake, then drain the R burst
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    case (state_q)
      S_IDLE: begin
        if (ifu_arvalid || lsu_arvalid) begin
          owner_d = grant_lsu ? OWN_LSU : OWN_IFU;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (own_arvalid && mem_arready) begin
          state_d      = S_DATA;
          last_owner_d = owner_q;
        end
      end
      S_DATA: begin
        if (mem_rvalid && own_rready && mem_rlast) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset drops to IDLE at once, which silences every output
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_IFU;
      last_owner_q <= OWN_IFU;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
    end
  end

  assign in_addr = (state_q == S_ADDR);
  assign in_data = (state_q == S_DATA);
  assign sel_ifu = (owner_q == OWN_IFU);
  assign sel_lsu = (owner_q == OWN_LSU);

  // Address channel: pass the owner's request through while in ADDR
  always_comb begin
    mem_arvalid = in_addr & own_arvalid;
    mem_araddr  = in_addr ? own_araddr : '0;
    mem_arlen   = in_addr ? own_arlen  : '0;
    mem_arsize  = in_addr ? own_arsize : '0;
    ifu_arready = in_addr & sel_ifu & mem_arready;
    lsu_arready = in_addr & sel_lsu & mem_arready;
  end

  // Data channel: steer memory beats to the owner while in DATA
  always_comb begin
    mem_rready = in_data & own_rready;
    ifu_rvalid = in_data & sel_ifu & mem_rvalid;
    ifu_rdata  = (in_data & sel_ifu) ? mem_rdata : '0;
    ifu_rresp  = (in_data & sel_ifu) ? mem_rresp : '0;
    ifu_rlast  = in_data & sel_ifu & mem_rlast;
    lsu_rvalid = in_data & sel_lsu & mem_rvalid;
    lsu_rdata  = (in_data & sel_lsu) ? mem_rdata : '0;
    lsu_rresp  = (in_data & sel_lsu) ? mem_rresp : '0;
    lsu_rlast  = in_data & sel_lsu & mem_rlast;
  end

endmodule

// File: doc/ysyx_23060203_mem_arb.md
YSYX_23060203_MEM_ARB -- requirements
Module: ysyx_23060203_mem_arb

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, giving the width of all araddr ports.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have IFU AR ports ifu_arvalid/arready/araddr/arlen/arsize: in/out/in/in/in, 1/1/ADDR_W/8/3, instruction-cache read address.
REQ-005 The block SHALL have IFU R ports ifu_rvalid/rready/rdata/rresp/rlast: out/in/out/out/out, 1/1/32/2/1, instruction-cache read data.
REQ-006 The block SHALL have LSU AR ports lsu_arvalid/arready/araddr/arlen/arsize: in/out/in/in/in, 1/1/ADDR_W/8/3, load read address.
REQ-007 The block SHALL have LSU R ports lsu_rvalid/rready/rdata/rresp/rlast: out/in/out/out/out, 1/1/32/2/1, load read data.
REQ-008 The block SHALL have memory AR ports mem_arvalid/arready/araddr/arlen/arsize: out/in/out/out/out, 1/1/ADDR_W/8/3, downstream read address.
REQ-009 The block SHALL have memory R ports mem_rvalid/rready/rdata/rresp/rlast: in/out/in/in/in, 1/1/32/2/1, downstream read data.
REQ-010 The block SHALL NOT carry write channels; LSU AW/W/B route around it.

Function
REQ-011 The FSM SHALL have the states IDLE, ADDR and DATA, plus a registered owner (IFU/LSU) and a registered last_owner.
REQ-012 In IDLE with any arvalid high, the FSM SHALL select the winner per REQ-020, latch it as owner, and go to ADDR on the next edge; the latency from request to mem_arvalid SHALL be 1 cycle.
REQ-013 In IDLE, all arready, rvalid and mem_arvalid outputs SHALL be 0, and mem_rready SHALL be 0.
REQ-014 In ADDR, mem_arvalid/araddr/arlen/arsize SHALL combinationally equal the owner's AR signals, and the owner's arready SHALL equal mem_arready; the non-owner's arready SHALL be 0.
REQ-015 In ADDR, on an owner AR handshake the FSM SHALL go to DATA and set last_owner to owner.
REQ-016 In DATA, the owner's rvalid/rdata/rresp/rlast SHALL follow the mem R signals and mem_rready SHALL equal the owner's rready; the non-owner's rvalid SHALL be 0.
REQ-017 In DATA, on a handshake with rlast=1 the FSM SHALL return to IDLE; beats without rlast SHALL keep DATA, so bursts up to arlen+1=256 beats are supported.
REQ-018 The block SHALL allow only one outstanding transaction; a new grant SHALL NOT occur in the same cycle as the final rlast handshake (IDLE is always visited, giving a 1-cycle bubble).
REQ-019 The non-owner's arvalid held during ADDR/DATA SHALL wait without loss; requesters keep arvalid and payload stable until arready (AXI rule).
REQ-020 Winner selection on simultaneous requests SHALL be per REQ-025/026; a lone request SHALL always win.
REQ-021 rresp SHALL pass through unmodified (SLVERR/DECERR included), and the FSM SHALL still end the transaction on rlast.
REQ-022 An owner deasserting arvalid in ADDR (protocol violation) SHALL leave the FSM in ADDR; no timeout SHALL exist.

Reset
REQ-023 Reset SHALL be asserted asynchronously and released synchronously by the integrator; while it is asserted, state SHALL be IDLE, owner=IFU and last_owner=IFU.
REQ-024 During reset all valid/ready outputs SHALL be 0; a reset mid-transaction SHALL abandon it, and the downstream slave is reset by the same signal.

Configuration
REQ-025 With macro YSYX_23060203_ARB_RR_EN defined, simultaneous requests SHALL be granted to the requester that is not last_owner (round-robin).
REQ-026 Without YSYX_23060203_ARB_RR_EN, simultaneous requests SHALL always be granted to LSU (fixed priority), and last_owner SHALL be kept but unused.

Verification
REQ-027 Test 1: IFU-only, araddr=0x30000000, arlen=3, 4 beats -> mem_arvalid rises 1 cycle after ifu_arvalid, 4 beats reach the IFU, lsu_rvalid stays 0, and IDLE follows the 4th beat.
REQ-028 Test 2: IFU and LSU assert arvalid in the same cycle with the macro off -> LSU is granted (mem_araddr=lsu_araddr=0x80001000) and the IFU is served after the LSU rlast plus a 1-cycle bubble.
REQ-029 Test 3: macro on, last_owner=LSU, both assert arvalid -> the IFU is granted first; repeating both requests alternates IFU, LSU, IFU.
REQ-030 Test 4: LSU read returns rresp=2'b10 with rlast=1 -> lsu_rresp=2'b10, FSM returns to IDLE, and the next IFU request is served normally.
REQ-031 Test 5: mem_rvalid held with owner rready=0 for 5 cycles -> mem_rready=0 for those cycles and no beat is lost or duplicated.
REQ-032 Test 6: reset asserted in DATA mid-burst -> all outputs 0 immediately (asynchronously), then IDLE; after release, a new IFU request completes.
